// File: rtl/spi_axi_pkg.sv
// Shared types and sizing helpers for the spi_axi slave memory.
package spi_axi_pkg;

  // Write-channel controller states
  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } w_state_e;

  // Read-channel controller states
  typedef enum logic [1:0] {
    R_IDLE  = 2'd0,
    R_FETCH = 2'd1,
    R_DATA  = 2'd2
  } r_state_e;

  // Default geometry of the memory
  localparam int unsigned C_DEF_DATA_WIDTH = 32;
  localparam int unsigned C_DEF_MEM_DEPTH  = 4096;

  // Byte lanes in one data word
  function automatic int unsigned byte_lanes(input int unsigned data_width);
    return data_width / 8;
  endfunction

  // Width of a word index into a memory of the given depth
  function automatic int unsigned idx_width(input int unsigned depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/spi_axi_ram.sv
// One write port with byte enables plus two independent synchronous read
// ports. Reads return the word as it was before a same-cycle write.
module spi_axi_ram
  import spi_axi_pkg::*;
#(
  parameter int unsigned C_DATA_WIDTH = C_DEF_DATA_WIDTH,
  parameter int unsigned C_MEM_DEPTH  = C_DEF_MEM_DEPTH
) (
  input  logic                             clk_i,
  input  logic                             we_i,
  input  logic [idx_width(C_MEM_DEPTH)-1:0] waddr_i,
  input  logic [C_DATA_WIDTH/8-1:0]        wbe_i,
  input  logic [C_DATA_WIDTH-1:0]          wdata_i,
  input  logic                             a_re_i,
  input  logic [idx_width(C_MEM_DEPTH)-1:0] a_raddr_i,
  output logic [C_DATA_WIDTH-1:0]          a_rdata_o,
  input  logic [idx_width(C_MEM_DEPTH)-1:0] b_raddr_i,
  output logic [C_DATA_WIDTH-1:0]          b_rdata_o
);

  localparam int unsigned LANES = byte_lanes(C_DATA_WIDTH);

  logic [C_DATA_WIDTH-1:0] mem [C_MEM_DEPTH];
  logic [C_DATA_WIDTH-1:0] a_rdata_q;
  logic [C_DATA_WIDTH-1:0] b_rdata_q;

  // Byte-masked write and both reads; non-blocking updates give read-first
  always_ff @(posedge clk_i) begin
    for (int b = 0; b < LANES; b++) begin
      if (we_i && wbe_i[b]) begin
        mem[waddr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
      end
    end
    if (a_re_i) begin
      a_rdata_q <= mem[a_raddr_i];
    end
    b_rdata_q <= mem[b_raddr_i];
  end

  assign a_rdata_o = a_rdata_q;
  assign b_rdata_o = b_rdata_q;

endmodule

// File: rtl/spi_axi_slave_mem.sv
// Reduced AXI4 slave memory: INCR write/read bursts into a local RAM, with a
// host side port for preloading and inspecting the image.
//
// Handshakes: a transfer happens on a rising edge where both valid and ready
// are 1. A source never drops valid or changes its payload before that edge;
// here rvalid/rdata/rlast and bvalid are held until accepted.
module spi_axi_slave_mem
  import spi_axi_pkg::*;
#(
  parameter int unsigned C_ADDR_WIDTH = 64,
  parameter int unsigned C_DATA_WIDTH = C_DEF_DATA_WIDTH,
  parameter int unsigned C_MEM_DEPTH  = C_DEF_MEM_DEPTH
) (
  input  logic                             ap_clk,
  input  logic                             ap_rst_n,
  input  logic                             s_axi_awvalid,
  output logic                             s_axi_awready,
  input  logic [C_ADDR_WIDTH-1:0]          s_axi_awaddr,
  input  logic [7:0]                       s_axi_awlen,
  input  logic                             s_axi_wvalid,
  output logic                             s_axi_wready,
  input  logic [C_DATA_WIDTH-1:0]          s_axi_wdata,
  input  logic [C_DATA_WIDTH/8-1:0]        s_axi_wstrb,
  input  logic                             s_axi_wlast,
  output logic                             s_axi_bvalid,
  input  logic                             s_axi_bready,
  input  logic                             s_axi_arvalid,
  output logic                             s_axi_arready,
  input  logic [C_ADDR_WIDTH-1:0]          s_axi_araddr,
  input  logic [7:0]                       s_axi_arlen,
  output logic                             s_axi_rvalid,
  input  logic                             s_axi_rready,
  output logic [C_DATA_WIDTH-1:0]          s_axi_rdata,
  output logic                             s_axi_rlast,
  input  logic                             host_we,
  input  logic [idx_width(C_MEM_DEPTH)-1:0] host_addr,
  input  logic [C_DATA_WIDTH-1:0]          host_wdata,
  output logic [C_DATA_WIDTH-1:0]          host_rdata,
  output logic                             wlast_err,
  output logic [1:0]                       w_state_o,
  output logic [1:0]                       r_state_o
);

  localparam int unsigned LANES    = byte_lanes(C_DATA_WIDTH);
  localparam int unsigned ADDR_LSB = $clog2(LANES);
  localparam int unsigned IDX_W    = idx_width(C_MEM_DEPTH);

  // Write channel state
  w_state_e         w_state_q;
  logic             awready_q;
  logic             wready_q;
  logic             bvalid_q;
  logic             wlast_err_q;
  logic [IDX_W-1:0] w_idx_q;
  logic [7:0]       w_cnt_q;

  // Read channel state
  r_state_e         r_state_q;
  logic             arready_q;
  logic             rvalid_q;
  logic             rlast_q;
  logic [IDX_W-1:0] r_idx_q;
  logic [7:0]       r_cnt_q;

  logic aw_hs;
  logic w_hs;
  logic ar_hs;
  logic r_hs;
  logic r_re;

  logic                    ram_we;
  logic [IDX_W-1:0]        ram_waddr;
  logic [LANES-1:0]        ram_wbe;
  logic [C_DATA_WIDTH-1:0] ram_wdata;

  // Address bits above the word index and below the lane offset are ignored
  logic unused_addr_bits;
  assign unused_addr_bits = ^{s_axi_awaddr, s_axi_araddr};

  // Host writes own the RAM write port for the cycle, so AXI data stalls
  assign s_axi_wready = wready_q & ~host_we;

  assign aw_hs = s_axi_awvalid & awready_q;
  assign w_hs  = s_axi_wvalid & s_axi_wready;
  assign ar_hs = s_axi_arvalid & arready_q;
  assign r_hs  = rvalid_q & s_axi_rready;

  // Fetch the first beat, then prefetch the next beat on every non-last accept
  assign r_re = (r_state_q == R_FETCH) | (r_hs & ~rlast_q);

  assign ram_we    = host_we | w_hs;
  assign ram_waddr = host_we ? host_addr : w_idx_q;
  assign ram_wbe   = host_we ? {LANES{1'b1}} : s_axi_wstrb;
  assign ram_wdata = host_we ? host_wdata : s_axi_wdata;

  // Write burst controller: address, data beats counted by awlen, response
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      w_state_q   <= W_IDLE;
      awready_q   <= 1'b0;
      wready_q    <= 1'b0;
      bvalid_q    <= 1'b0;
      wlast_err_q <= 1'b0;
      w_idx_q     <= '0;
      w_cnt_q     <= '0;
    end else begin
      case (w_state_q)
        W_IDLE: begin
          awready_q <= 1'b1;
          if (aw_hs) begin
            awready_q <= 1'b0;
            wready_q  <= 1'b1;
            w_idx_q   <= s_axi_awaddr[ADDR_LSB +: IDX_W];
            w_cnt_q   <= s_axi_awlen;
            w_state_q <= W_DATA;
          end
        end
        W_DATA: begin
          if (w_hs) begin
            // wlast is only reported on; the beat count ends the burst
            if (s_axi_wlast != (w_cnt_q == 8'd0)) begin
              wlast_err_q <= 1'b1;
            end
            w_idx_q <= w_idx_q + IDX_W'(1);
            if (w_cnt_q == 8'd0) begin
              wready_q  <= 1'b0;
              bvalid_q  <= 1'b1;
              w_state_q <= W_RESP;
            end else begin
              w_cnt_q <= w_cnt_q - 8'd1;
            end
          end
        end
        W_RESP: begin
          if (s_axi_bready) begin
            bvalid_q  <= 1'b0;
            awready_q <= 1'b1;
            w_state_q <= W_IDLE;
          end
        end
        default: begin
          w_state_q <= W_IDLE;
        end
      endcase
    end
  end

  // Read burst controller: address, one fetch cycle, then streamed beats
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_state_q <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      r_idx_q   <= '0;
      r_cnt_q   <= '0;
    end else begin
      case (r_state_q)
        R_IDLE: begin
          arready_q <= 1'b1;
          if (ar_hs) begin
            arready_q <= 1'b0;
            r_idx_q   <= s_axi_araddr[ADDR_LSB +: IDX_W];
            r_cnt_q   <= s_axi_arlen;
            r_state_q <= R_FETCH;
          end
        end
        R_FETCH: begin
          r_idx_q   <= r_idx_q + IDX_W'(1);
          rvalid_q  <= 1'b1;
          rlast_q   <= (r_cnt_q == 8'd0);
          r_state_q <= R_DATA;
        end
        R_DATA: begin
          if (r_hs) begin
            if (rlast_q) begin
              rvalid_q  <= 1'b0;
              rlast_q   <= 1'b0;
              arready_q <= 1'b1;
              r_state_q <= R_IDLE;
            end else begin
              r_idx_q <= r_idx_q + IDX_W'(1);
              r_cnt_q <= r_cnt_q - 8'd1;
              rlast_q <= (r_cnt_q == 8'd1);
            end
          end
        end
        default: begin
          r_state_q <= R_IDLE;
        end
      endcase
    end
  end

  spi_axi_ram #(
    .C_DATA_WIDTH (C_DATA_WIDTH),
    .C_MEM_DEPTH  (C_MEM_DEPTH)
  ) u_ram (
    .clk_i     (ap_clk),
    .we_i      (ram_we),
    .waddr_i   (ram_waddr),
    .wbe_i     (ram_wbe),
    .wdata_i   (ram_wdata),
    .a_re_i    (r_re),
    .a_raddr_i (r_idx_q),
    .a_rdata_o (s_axi_rdata),
    .b_raddr_i (host_addr),
    .b_rdata_o (host_rdata)
  );

  assign s_axi_awready = awready_q;
  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_arready = arready_q;
  assign s_axi_rvalid  = rvalid_q;
  assign s_axi_rlast   = rlast_q;
  assign wlast_err     = wlast_err_q;
  assign w_state_o     = w_state_q;
  assign r_state_o     = r_state_q;

endmodule

// File: tb/tb_spi_axi_slave_mem.sv
// Directed bench for spi_axi_slave_mem with a 16-word, 32-bit memory.
module tb_spi_axi_slave_mem;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        awvalid, awready;
  logic [63:0] awaddr;
  logic [7:0]  awlen;
  logic        wvalid, wready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        bvalid, bready;
  logic        arvalid, arready;
  logic [63:0] araddr;
  logic [7:0]  arlen;
  logic        rvalid, rready;
  logic [31:0] rdata;
  logic        rlast;
  logic        host_we;
  logic [3:0]  host_addr;
  logic [31:0] host_wdata;
  logic [31:0] host_rdata;
  logic        wlast_err;
  logic [1:0]  w_state, r_state;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  spi_axi_slave_mem #(
    .C_ADDR_WIDTH (64),
    .C_DATA_WIDTH (32),
    .C_MEM_DEPTH  (16)
  ) dut (
    .ap_clk        (clk),
    .ap_rst_n      (rst_n),
    .s_axi_awvalid (awvalid),
    .s_axi_awready (awready),
    .s_axi_awaddr  (awaddr),
    .s_axi_awlen   (awlen),
    .s_axi_wvalid  (wvalid),
    .s_axi_wready  (wready),
    .s_axi_wdata   (wdata),
    .s_axi_wstrb   (wstrb),
    .s_axi_wlast   (wlast),
    .s_axi_bvalid  (bvalid),
    .s_axi_bready  (bready),
    .s_axi_arvalid (arvalid),
    .s_axi_arready (arready),
    .s_axi_araddr  (araddr),
    .s_axi_arlen   (arlen),
    .s_axi_rvalid  (rvalid),
    .s_axi_rready  (rready),
    .s_axi_rdata   (rdata),
    .s_axi_rlast   (rlast),
    .host_we       (host_we),
    .host_addr     (host_addr),
    .host_wdata    (host_wdata),
    .host_rdata    (host_rdata),
    .wlast_err     (wlast_err),
    .w_state_o     (w_state),
    .r_state_o     (r_state)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic host_wr(input logic [3:0] a, input logic [31:0] d);
    host_we    = 1'b1;
    host_addr  = a;
    host_wdata = d;
    tick();
    host_we    = 1'b0;
  endtask

  task automatic host_rd(input logic [3:0] a, output logic [31:0] d);
    host_addr = a;
    tick();
    @(negedge clk);
    d = host_rdata;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    awvalid = 0; awaddr = '0; awlen = '0;
    wvalid = 0; wdata = '0; wstrb = '0; wlast = 0; bready = 0;
    arvalid = 0; araddr = '0; arlen = '0; rready = 0;
    host_we = 0; host_addr = '0; host_wdata = '0;
    repeat (2) tick();
    @(negedge clk);
    checks++; if ({awready, wready, bvalid, arready, rvalid, rlast, wlast_err} !== 7'b0) begin
      errors++; $display("FAIL reset_outputs: got %b want 0000000", {awready, wready, bvalid, arready, rvalid, rlast, wlast_err});
    end
    checks++; if ({w_state, r_state} !== 4'b0) begin
      errors++; $display("FAIL reset_states: got %b want 0000", {w_state, r_state});
    end
    rst_n = 1'b1;
    tick();
    @(negedge clk);
    checks++; if ({awready, arready} !== 2'b11) begin
      errors++; $display("FAIL reset_ready_after_release: got %b want 11", {awready, arready});
    end
    tick();
  endtask

  task automatic test_read_burst();
    for (int i = 0; i < 4; i++) begin
      host_wr(i[3:0], 32'h11 * (i + 1));
      exp_q.push_back(32'h11 * (i + 1));
    end
    araddr = 64'h0; arlen = 8'd3; arvalid = 1'b1; rready = 1'b1;
    @(negedge clk);
    checks++; if (arready !== 1'b1) begin errors++; $display("FAIL rd_arready: got %b want 1", arready); end
    tick();
    arvalid = 1'b0;
    @(negedge clk);
    checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL rd_fetch_rvalid: got %b want 0", rvalid); end
    tick();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++; if ({rvalid, rlast, rdata} !== {1'b1, exp_q.size() == 1, exp_q[0]}) begin
        errors++; $display("FAIL rd_beat%0d: got v=%b l=%b d=%h want v=1 l=%b d=%h", i, rvalid, rlast, rdata, exp_q.size() == 1, exp_q[0]);
      end
      void'(exp_q.pop_front());
      tick();
    end
    @(negedge clk);
    checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL rd_end_rvalid: got %b want 0", rvalid); end
    rready = 1'b0;
    tick();
  endtask

  task automatic test_write_burst();
    logic [31:0] d;
    awaddr = 64'h8; awlen = 8'd1; awvalid = 1'b1;
    @(negedge clk);
    checks++; if (awready !== 1'b1) begin errors++; $display("FAIL wr_awready: got %b want 1", awready); end
    tick();
    awvalid = 1'b0;
    wvalid = 1'b1; wdata = 32'hDEADBEEF; wstrb = 4'hF; wlast = 1'b0;
    @(negedge clk);
    checks++; if (wready !== 1'b1) begin errors++; $display("FAIL wr_wready: got %b want 1", wready); end
    tick();
    wdata = 32'hCAFEF00D; wlast = 1'b1;
    @(negedge clk);
    checks++; if (bvalid !== 1'b0) begin errors++; $display("FAIL wr_early_bvalid: got %b want 0", bvalid); end
    tick();
    wvalid = 1'b0; wlast = 1'b0; bready = 1'b1;
    @(negedge clk);
    checks++; if ({bvalid, awready} !== 2'b10) begin errors++; $display("FAIL wr_resp: got bv/awr=%b want 10", {bvalid, awready}); end
    tick();
    bready = 1'b0;
    @(negedge clk);
    checks++; if ({bvalid, awready, wlast_err} !== 3'b010) begin errors++; $display("FAIL wr_after_resp: got %b want 010", {bvalid, awready, wlast_err}); end
    tick();
    host_rd(4'd2, d);
    checks++; if (d !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_idx2: got %h want deadbeef", d); end
    host_rd(4'd3, d);
    checks++; if (d !== 32'hCAFEF00D) begin errors++; $display("FAIL wr_idx3: got %h want cafef00d", d); end
  endtask

  task automatic test_strobe();
    logic [31:0] d;
    host_wr(4'd5, 32'hAABBCCDD);
    awaddr = 64'h14; awlen = 8'd0; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    wvalid = 1'b1; wdata = 32'h11223344; wstrb = 4'b0101; wlast = 1'b1;
    tick();
    wvalid = 1'b0; wlast = 1'b0; wstrb = 4'hF; bready = 1'b1;
    @(negedge clk);
    checks++; if (bvalid !== 1'b1) begin errors++; $display("FAIL strb_bvalid_t2: got %b want 1", bvalid); end
    tick();
    bready = 1'b0;
    host_rd(4'd5, d);
    checks++; if (d !== 32'hAA22CC44) begin errors++; $display("FAIL strb_word5: got %h want aa22cc44", d); end
  endtask

  task automatic test_wrap();
    logic [31:0] d;
    awaddr = 64'h3C; awlen = 8'd1; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    wvalid = 1'b1; wdata = 32'hA5A5000F; wlast = 1'b0;
    tick();
    wdata = 32'h5A5A0000; wlast = 1'b1;
    tick();
    wvalid = 1'b0; wlast = 1'b0; bready = 1'b1;
    tick();
    bready = 1'b0;
    host_rd(4'd15, d);
    checks++; if (d !== 32'hA5A5000F) begin errors++; $display("FAIL wrap_idx15: got %h want a5a5000f", d); end
    host_rd(4'd0, d);
    checks++; if (d !== 32'h5A5A0000) begin errors++; $display("FAIL wrap_idx0: got %h want 5a5a0000", d); end
  endtask

  task automatic test_backpressure_read();
    logic pat [6];
    int cyc;
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    for (int i = 0; i < 4; i++) begin
      host_wr(4'(8 + i), 32'h8000_0000 | i);
      exp_q.push_back(32'h8000_0000 | i);
    end
    araddr = 64'h20; arlen = 8'd3; arvalid = 1'b1; rready = 1'b0;
    tick();
    arvalid = 1'b0;
    tick();
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 20) begin
      rready = (cyc < 6) ? pat[cyc] : 1'b1;
      @(negedge clk);
      checks++; if ({rvalid, rlast, rdata} !== {1'b1, exp_q.size() == 1, exp_q[0]}) begin
        errors++; $display("FAIL rbp_cyc%0d: got v=%b l=%b d=%h want v=1 l=%b d=%h", cyc, rvalid, rlast, rdata, exp_q.size() == 1, exp_q[0]);
      end
      if (rready) void'(exp_q.pop_front());
      cyc++;
      tick();
    end
    rready = 1'b0;
    @(negedge clk);
    checks++; if ({cyc, rvalid} !== {32'd6, 1'b0}) begin
      errors++; $display("FAIL rbp_done: got cycles=%0d rvalid=%b want cycles=6 rvalid=0", cyc, rvalid);
    end
    exp_q.delete();
    tick();
  endtask

  task automatic test_backpressure_write();
    logic [31:0] d;
    awaddr = 64'h18; awlen = 8'd0; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    wvalid = 1'b1; wdata = 32'h06060606; wlast = 1'b1;
    tick();
    wvalid = 1'b0; wlast = 1'b0; bready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++; if ({bvalid, awready} !== 2'b10) begin errors++; $display("FAIL wbp_hold%0d: got bv/awr=%b want 10", i, {bvalid, awready}); end
      tick();
    end
    bready = 1'b1;
    tick();
    bready = 1'b0;
    @(negedge clk);
    checks++; if ({bvalid, awready} !== 2'b01) begin errors++; $display("FAIL wbp_release: got bv/awr=%b want 01", {bvalid, awready}); end
    tick();
    host_rd(4'd6, d);
    checks++; if (d !== 32'h06060606) begin errors++; $display("FAIL wbp_idx6: got %h want 06060606", d); end
  endtask

  task automatic test_host_priority();
    logic [31:0] d;
    awaddr = 64'h10; awlen = 8'd0; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    wvalid = 1'b1; wdata = 32'h44444444; wlast = 1'b1;
    host_we = 1'b1; host_addr = 4'd9; host_wdata = 32'h99999999;
    @(negedge clk);
    checks++; if (wready !== 1'b0) begin errors++; $display("FAIL prio_stall_wready: got %b want 0", wready); end
    tick();
    host_we = 1'b0;
    @(negedge clk);
    checks++; if (wready !== 1'b1) begin errors++; $display("FAIL prio_resume_wready: got %b want 1", wready); end
    tick();
    wvalid = 1'b0; wlast = 1'b0; bready = 1'b1;
    tick();
    bready = 1'b0;
    host_rd(4'd4, d);
    checks++; if (d !== 32'h44444444) begin errors++; $display("FAIL prio_idx4: got %h want 44444444", d); end
    host_rd(4'd9, d);
    checks++; if (d !== 32'h99999999) begin errors++; $display("FAIL prio_idx9: got %h want 99999999", d); end
  endtask

  task automatic test_collision();
    logic [31:0] d;
    host_wr(4'd7, 32'h77777777);
    araddr = 64'h1C; arlen = 8'd0; arvalid = 1'b1; rready = 1'b1;
    tick();
    arvalid = 1'b0;
    host_we = 1'b1; host_addr = 4'd7; host_wdata = 32'hEEEEEEEE;
    tick();
    host_we = 1'b0;
    @(negedge clk);
    checks++; if ({rvalid, rlast, rdata} !== {2'b11, 32'h77777777}) begin
      errors++; $display("FAIL coll_read_first: got v=%b l=%b d=%h want v=1 l=1 d=77777777", rvalid, rlast, rdata);
    end
    tick();
    rready = 1'b0;
    host_rd(4'd7, d);
    checks++; if (d !== 32'hEEEEEEEE) begin errors++; $display("FAIL coll_new_data: got %h want eeeeeeee", d); end
  endtask

  task automatic test_wlast_err();
    logic [31:0] d;
    @(negedge clk);
    checks++; if (wlast_err !== 1'b0) begin errors++; $display("FAIL werr_initial: got %b want 0", wlast_err); end
    awaddr = 64'h30; awlen = 8'd2; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    wvalid = 1'b1; wdata = 32'hC0C0C0C0; wlast = 1'b1;
    tick();
    wdata = 32'hC1C1C1C1; wlast = 1'b0;
    @(negedge clk);
    checks++; if ({wlast_err, bvalid} !== 2'b10) begin errors++; $display("FAIL werr_flag: got err/bv=%b want 10", {wlast_err, bvalid}); end
    tick();
    wdata = 32'hC2C2C2C2;
    @(negedge clk);
    checks++; if ({wready, bvalid} !== 2'b10) begin errors++; $display("FAIL werr_third_beat: got wr/bv=%b want 10", {wready, bvalid}); end
    tick();
    wvalid = 1'b0; bready = 1'b1;
    @(negedge clk);
    checks++; if (bvalid !== 1'b1) begin errors++; $display("FAIL werr_bvalid: got %b want 1", bvalid); end
    tick();
    bready = 1'b0;
    @(negedge clk);
    checks++; if ({wlast_err, bvalid} !== 2'b10) begin errors++; $display("FAIL werr_sticky: got err/bv=%b want 10", {wlast_err, bvalid}); end
    tick();
    host_rd(4'd14, d);
    checks++; if (d !== 32'hC2C2C2C2) begin errors++; $display("FAIL werr_idx14: got %h want c2c2c2c2", d); end
  endtask

  task automatic test_reset_mid_read();
    int n;
    araddr = 64'h0; arlen = 8'd3; arvalid = 1'b1; rready = 1'b0;
    tick();
    arvalid = 1'b0;
    n = 0;
    while (!rvalid && n < 10) begin
      tick();
      n++;
    end
    checks++; if (rvalid !== 1'b1) begin errors++; $display("FAIL rst_wait_rvalid: got %b want 1", rvalid); end
    rst_n = 1'b0;
    #1;
    checks++; if ({rvalid, rlast, arready, wlast_err, r_state} !== 6'b0) begin
      errors++; $display("FAIL rst_async: got %b want 000000", {rvalid, rlast, arready, wlast_err, r_state});
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    @(negedge clk);
    checks++; if ({arready, rvalid} !== 2'b10) begin errors++; $display("FAIL rst_release: got arr/rv=%b want 10", {arready, rvalid}); end
    tick();
  endtask

  // Scenario sequence and final report
  initial begin
    test_reset();
    test_read_burst();
    test_write_burst();
    test_strobe();
    test_wrap();
    test_backpressure_read();
    test_backpressure_write();
    test_host_priority();
    test_collision();
    test_wlast_err();
    test_reset_mid_read();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
